// File: rtl/div_arb_pkg.sv
// div_arb_pkg: owner encoding and in-flight entry type shared by the divider arbiter and its tracker
package div_arb_pkg;
    localparam logic OWNER_REQ0 = 1'b0;
    localparam logic OWNER_REQ1 = 1'b1;
    typedef struct packed {
        logic valid;
        logic owner;
    } inflight_t;
endpackage

// File: rtl/div_share_arbiter_if.sv
// div_share_arbiter_if: requester, datapath and response signals of the shared divider arbiter
interface div_share_arbiter_if #(parameter int WIDTH = 64);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_dividend;
    logic [WIDTH-1:0] req0_divisor;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_dividend;
    logic [WIDTH-1:0] req1_divisor;
    logic             dp_valid;
    logic [WIDTH-1:0] dp_dividend;
    logic [WIDTH-1:0] dp_divisor;
    logic [WIDTH-1:0] dp_result;
    logic             rsp0_valid;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp1_data;
    logic             flush;
    logic             busy;
    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        input  dp_result, flush,
        output req0_ready, req1_ready, dp_valid, dp_dividend, dp_divisor,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
    );
    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        output dp_result, flush,
        input  req0_ready, req1_ready, dp_valid, dp_dividend, dp_divisor,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
    );
endinterface

// File: rtl/div_inflight_tracker.sv
// div_inflight_tracker: LATENCY-deep {valid, owner} shift line matching the divider pipeline
module div_inflight_tracker
    import div_arb_pkg::*;
#(
    parameter int LATENCY = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    input  logic owner,
    input  logic flush,
    output logic retire_valid,
    output logic retire_owner,
    output logic busy
);
    inflight_t r_line [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < LATENCY; i++) r_line[i] <= '0;
        end else begin
            r_line[0] <= '{valid: issue, owner: owner};
            for (int i = 1; i < LATENCY; i++) r_line[i] <= r_line[i-1];
        end
    end

    assign retire_valid = r_line[LATENCY-1].valid;
    assign retire_owner = r_line[LATENCY-1].owner;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) busy = busy | r_line[i].valid;
    end
endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: two requesters sharing one fixed-latency divider, round-robin issue and tagged responses.
// Define DIV_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 10
) (
    input logic               clk,
    input logic               rst_n,
    div_share_arbiter_if.slave bus
);
    logic w_en;
    logic w_pref0;
    logic w_gnt0;
    logic w_gnt1;
    logic w_rsp0;
    logic w_rsp1;
    logic w_ret_v;
    logic w_ret_own;
    logic w_busy;

`ifdef DIV_ARB_FIXED_PRIO_EN
    assign w_pref0 = 1'b1;
`else
    logic r_last;
    // Reset points at requester 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) r_last <= OWNER_REQ1;
        else if (w_gnt0 || w_gnt1) r_last <= w_gnt1 ? OWNER_REQ1 : OWNER_REQ0;
    end
    assign w_pref0 = (r_last == OWNER_REQ1);
`endif

    always_comb begin
        w_en            = rst_n && !bus.flush;
        w_gnt0          = w_en && bus.req0_valid && (!bus.req1_valid || w_pref0);
        w_gnt1          = w_en && bus.req1_valid && !w_gnt0;
        w_rsp0          = w_en && w_ret_v && (w_ret_own == OWNER_REQ0);
        w_rsp1          = w_en && w_ret_v && (w_ret_own == OWNER_REQ1);
        bus.req0_ready  = w_gnt0;
        bus.req1_ready  = w_gnt1;
        bus.dp_valid    = w_gnt0 || w_gnt1;
        bus.dp_dividend = w_gnt0 ? bus.req0_dividend : w_gnt1 ? bus.req1_dividend : {WIDTH{1'b0}};
        bus.dp_divisor  = w_gnt0 ? bus.req0_divisor  : w_gnt1 ? bus.req1_divisor  : {WIDTH{1'b0}};
        bus.rsp0_valid  = w_rsp0;
        bus.rsp1_valid  = w_rsp1;
        bus.rsp0_data   = w_rsp0 ? bus.dp_result : {WIDTH{1'b0}};
        bus.rsp1_data   = w_rsp1 ? bus.dp_result : {WIDTH{1'b0}};
        bus.busy        = rst_n && w_busy;
    end

    div_inflight_tracker #(.LATENCY(LATENCY)) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue        (w_gnt0 || w_gnt1),
        .owner        (w_gnt1 ? OWNER_REQ1 : OWNER_REQ0),
        .flush        (bus.flush),
        .retire_valid (w_ret_v),
        .retire_owner (w_ret_own),
        .busy         (w_busy)
    );
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: vector table, directed corner sequences and random traffic against an op-queue model
module tb_div_share_arbiter;
    localparam int W = 64;
    localparam int L = 10;
`ifdef DIV_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n1 = 1'b0;
    always #5 clk = ~clk;

    div_share_arbiter_if #(.WIDTH(W)) bus ();
    div_share_arbiter_if #(.WIDTH(W)) bus1 ();
    div_share_arbiter #(.WIDTH(W), .LATENCY(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    div_share_arbiter #(.WIDTH(W), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n1), .bus(bus1));

    typedef struct {
        int           rc;
        bit           own;
        logic [W-1:0] q;
    } op_t;

    typedef struct {
        bit v0, v1;
        bit r0_rr, r1_rr, r0_fx, r1_fx;
    } vec_t;

    op_t          pend[$];
    int           n_checks = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           m_last = 1'b1;
    logic [W-1:0] dpp [L];
    logic         s_r0, s_r1, s_dv, s_rsp0, s_rsp1, s_busy;
    logic [W-1:0] s_dd, s_ds, s_d0, s_d1;

    function automatic logic [W-1:0] qdiv(logic [W-1:0] a, logic [W-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chkb(string nm, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0b expected %0b", nm, cyc, act, exp);
        end
    endtask

    // One clock of the L=10 DUT: drive, sample at negedge, compare with the op-queue model
    task automatic step(bit rn, bit fl, bit v0, bit v1,
                        logic [W-1:0] a0, logic [W-1:0] b0, logic [W-1:0] a1, logic [W-1:0] b1);
        int           w;
        op_t          o;
        bit           eb, er0, er1;
        logic [W-1:0] ed0, ed1;
        er0 = 1'b0; er1 = 1'b0; ed0 = '0; ed1 = '0;
        rst_n = rn;
        bus.flush = fl;
        bus.req0_valid = v0; bus.req0_dividend = a0; bus.req0_divisor = b0;
        bus.req1_valid = v1; bus.req1_dividend = a1; bus.req1_divisor = b1;
        bus.dp_result = dpp[L-1];
        @(negedge clk);
        s_r0 = bus.req0_ready; s_r1 = bus.req1_ready; s_dv = bus.dp_valid;
        s_dd = bus.dp_dividend; s_ds = bus.dp_divisor;
        s_rsp0 = bus.rsp0_valid; s_rsp1 = bus.rsp1_valid; s_d0 = bus.rsp0_data; s_d1 = bus.rsp1_data;
        s_busy = bus.busy;
        eb = rn && (pend.size() != 0);
        if (rn && !fl && pend.size() != 0 && pend[0].rc == cyc) begin
            o = pend.pop_front();
            if (o.own) begin er1 = 1'b1; ed1 = o.q; end
            else begin er0 = 1'b1; ed0 = o.q; end
        end
        if (!rn || fl) pend.delete();
        w = -1;
        if (rn && !fl) begin
            if (v0 && v1) w = (FIXED || m_last) ? 0 : 1;
            else if (v0) w = 0;
            else if (v1) w = 1;
        end
        if (!rn) m_last = 1'b1;
        if (w >= 0) begin
            m_last = (w == 1);
            pend.push_back('{cyc + L, w == 1, (w == 1) ? qdiv(a1, b1) : qdiv(a0, b0)});
        end
        chkb("req0_ready", s_r0, w == 0);
        chkb("req1_ready", s_r1, w == 1);
        chkb("dp_valid", s_dv, w >= 0);
        chk("dp_dividend", s_dd, (w == 0) ? a0 : (w == 1) ? a1 : '0);
        chk("dp_divisor", s_ds, (w == 0) ? b0 : (w == 1) ? b1 : '0);
        chkb("rsp0_valid", s_rsp0, er0);
        chkb("rsp1_valid", s_rsp1, er1);
        chk("rsp0_data", s_d0, ed0);
        chk("rsp1_data", s_d1, ed1);
        chkb("busy", s_busy, eb);
        for (int i = L - 1; i > 0; i--) dpp[i] = dpp[i-1];
        dpp[0] = s_dv ? qdiv(s_dd, s_ds) : '0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 64'd5, 64'd1, 64'd6, 64'd1);
        cyc = 0;
    endtask

    initial begin
        vec_t tbl [8];
        tbl[0] = '{1, 1, 1, 0, 1, 0};
        tbl[1] = '{1, 1, 0, 1, 1, 0};
        tbl[2] = '{1, 1, 1, 0, 1, 0};
        tbl[3] = '{1, 1, 0, 1, 1, 0};
        tbl[4] = '{0, 1, 0, 1, 0, 1};
        tbl[5] = '{1, 0, 1, 0, 1, 0};
        tbl[6] = '{1, 1, 0, 1, 1, 0};
        tbl[7] = '{1, 1, 1, 0, 1, 0};
        for (int i = 0; i < L; i++) dpp[i] = '0;
        bus1.req0_valid = 1'b0; bus1.req0_dividend = '0; bus1.req0_divisor = '0;
        bus1.req1_valid = 1'b0; bus1.req1_dividend = '0; bus1.req1_divisor = '0;
        bus1.dp_result = '0; bus1.flush = 1'b0;
        @(posedge clk);
        #1;

        // Contention table: alternating grants, then responses 10..13 in grant order
        do_reset();
        chkb("reset_busy", s_busy, 1'b0);
        chkb("reset_dp_valid", s_dv, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, tbl[i].v0, tbl[i].v1, 64'(100 + i), 64'd7, 64'(200 + i), 64'd3);
            chkb("tbl_ready0", s_r0, FIXED ? tbl[i].r0_fx : tbl[i].r0_rr);
            chkb("tbl_ready1", s_r1, FIXED ? tbl[i].r1_fx : tbl[i].r1_rr);
        end
        idle(2);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chkb("contend_rsp0", s_rsp0, FIXED ? 1'b1 : (k % 2 == 0));
            chkb("contend_rsp1", s_rsp1, FIXED ? 1'b0 : (k % 2 == 1));
        end
        idle(6);

        // Single op 100/7 at cycle 5 responds at cycle 15
        do_reset();
        idle(5);
        step(1, 0, 1, 0, 64'd100, 64'd7, '0, '0);
        chkb("single_dp_valid", s_dv, 1'b1);
        idle(10);
        chkb("single_rsp0", s_rsp0, 1'b1);
        chk("single_data", s_d0, 64'd14);
        chkb("single_rsp1", s_rsp1, 1'b0);

        // Flush kills ops issued 0..2; new issue at 5 responds at 15
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 64'(50 + i), 64'd5, 64'(90 + i), 64'd9);
        idle(1);
        step(1, 1, 1, 1, 64'd1, 64'd1, 64'd1, 64'd1);
        chkb("flush_ready0", s_r0, 1'b0);
        chkb("flush_ready1", s_r1, 1'b0);
        step(1, 0, 0, 1, '0, '0, 64'd81, 64'd9);
        chkb("flush_busy", s_busy, 1'b0);
        chkb("flush_resume", s_r1, 1'b1);
        idle(4);
        step(1, 0, 0, 0, '0, '0, '0, '0);
        chkb("flush_no_rsp0", s_rsp0, 1'b0);
        chkb("flush_no_rsp1", s_rsp1, 1'b0);
        idle(5);
        chkb("flush_new_rsp1", s_rsp1, 1'b1);
        chk("flush_new_data", s_d1, 64'd9);

        // Reset mid-flight discards the op and zeroes outputs
        do_reset();
        step(1, 0, 1, 0, 64'd77, 64'd7, '0, '0);
        idle(2);
        step(0, 0, 1, 1, 64'd8, 64'd2, 64'd9, 64'd3);
        chkb("rst_ready0", s_r0, 1'b0);
        chkb("rst_dp_valid", s_dv, 1'b0);
        chkb("rst_busy", s_busy, 1'b0);
        idle(7);
        chkb("rst_no_rsp0", s_rsp0, 1'b0);

        // Random traffic with occasional flush and reset
        do_reset();
        for (int i = 0; i < 800; i++)
            step(($urandom % 150) != 0, ($urandom % 40) == 0, 1'($urandom), 1'($urandom),
                 {$urandom, $urandom}, 64'($urandom_range(0, 20)),
                 {$urandom, $urandom}, 64'($urandom_range(0, 20)));
        idle(L + 1);

        // LATENCY=1 stream on requester 1
        @(posedge clk);
        #1;
        rst_n1 = 1'b1;
        for (int k = 0; k < 22; k++) begin
            bus1.req1_valid = (k < 20);
            bus1.req1_dividend = 64'(1000 + k);
            bus1.req1_divisor = 64'd1;
            bus1.dp_result = 64'(20480 + k);
            @(negedge clk);
            chkb("stream_ready1", bus1.req1_ready, k < 20);
            chkb("stream_rsp1", bus1.rsp1_valid, k >= 1 && k <= 20);
            chk("stream_data", bus1.rsp1_data, (k >= 1 && k <= 20) ? 64'(20480 + k) : '0);
            chkb("stream_busy", bus1.busy, k >= 1 && k <= 20);
            chkb("stream_rsp0", bus1.rsp0_valid, 1'b0);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
